// File: rtl/nway_mux_skid_if.sv
// nway_mux_skid_if
//   Handshake/data bundle for the N-way mux with skid buffer.
//   Upstream side:   in_valid, in_ready, sel, in_data (input k = in_data[k*WIDTH +: WIDTH])
//   Downstream side: out_valid, out_ready, out_data, out_sel
//   Modports: slave  = the mux block itself
//             master = the environment driving it (upstream source + downstream sink)
//   Handshake rule, both sides: a transfer happens at a rising clk edge exactly when
//   valid and ready are both 1; the source holds its payload while valid=1 and ready=0.
interface nway_mux_skid_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
);
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;

  modport slave (
    input  in_valid, sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/nway_mux_skid.sv
// nway_mux_skid
//   N-way WIDTH-bit selector with a registered output stage and a 2-entry skid
//   buffer (MAIN drives the outputs, SKID catches one extra word while stalled).
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     bus       nway_mux_skid_if.slave: in_valid/in_ready/sel/in_data upstream,
//               out_valid/out_ready/out_data/out_sel downstream
//     err_clr   clears sel_err
//     sel_err   sticky flag: a select >= N was accepted
//     xfer_cnt  wrapping count of output handshakes
//     dbg_state occupancy state (EMPTY/ONE/FULL)
module nway_mux_skid #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  nway_mux_skid_if.slave    bus,
  input  logic              err_clr,
  output logic              sel_err,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             in_ready_q;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] xfer_cnt_q;

  logic [WIDTH-1:0] word;
  logic             sel_illegal;
  logic             accept;
  logic             emit;

  // Out-of-range selects fall through the loop and leave word at zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.sel == SEL_W'(k)) word = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // Extra top bit so N itself is representable for the compare.
  assign sel_illegal = ({1'b0, bus.sel} >= (SEL_W+1)'(N));

  assign accept = bus.in_valid & in_ready_q;
  assign emit   = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_data_d = word;
          main_sel_d  = bus.sel;
          state_d     = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && emit) begin
          main_data_d = word;
          main_sel_d  = bus.sel;
        end else if (accept) begin
          skid_data_d = word;
          skid_sel_d  = bus.sel;
          state_d     = S_FULL;
        end else if (emit) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (emit) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          state_d     = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Set has priority over clear so an error in the clearing cycle is not lost.
  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && sel_illegal) sel_err_d = 1'b1;
    else if (err_clr)          sel_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
      sel_err_q   <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      // Registered from next state: no combinational out_ready -> in_ready path.
      in_ready_q  <= (state_d != S_FULL);
      sel_err_q   <= sel_err_d;
      if (emit) xfer_cnt_q <= xfer_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.out_data  = main_data_q;
  assign bus.out_sel   = main_sel_q;
  assign sel_err       = sel_err_q;
  assign xfer_cnt      = xfer_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_nway_mux_skid.sv
// tb_nway_mux_skid
//   Bench for nway_mux_skid: instance A (N=4, CNT_W=16) and instance B (N=3, CNT_W=4).
module tb_nway_mux_skid;

  logic clk;
  logic rst;
  logic clr_a, clr_b;
  logic err_a, err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [1:0]  st_a, st_b;

  int n_total;
  int n_pass;

  nway_mux_skid_if #(.WIDTH(32), .N(4)) bus_a ();
  nway_mux_skid_if #(.WIDTH(32), .N(3)) bus_b ();

  nway_mux_skid #(.WIDTH(32), .N(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .err_clr(clr_a),
    .sel_err(err_a), .xfer_cnt(cnt_a), .dbg_state(st_a)
  );

  nway_mux_skid #(.WIDTH(32), .N(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .err_clr(clr_b),
    .sel_err(err_b), .xfer_cnt(cnt_b), .dbg_state(st_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- vector table for instance A ----------------
  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [31:0] ed;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs[8];

  // Scoreboard for the random phase: {sel, data}
  logic [33:0] exp_q[$];

  initial begin
    logic [31:0] w[4];
    logic [33:0] e;
    logic        m_acc, m_emit;
    logic [1:0]  rsel;
    int          n_emit;

    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.sel = '0;
    bus_a.in_data = {32'h4, 32'h3, 32'h2, 32'h1};
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.sel = '0;
    bus_b.in_data = {32'h30, 32'h20, 32'h10};

    //            iv    sel    ordy   ev    er    ed          es
    vecs[0] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h3, 2'd2}; // basic select
    vecs[1] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h0, 2'd0}; // drain to empty
    vecs[2] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'h1, 2'd0}; // stall: first accept
    vecs[3] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 32'h1, 2'd0}; // second accept -> full
    vecs[4] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h1, 2'd0}; // refused, output held
    vecs[5] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h2, 2'd1}; // release: h2 next
    vecs[6] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 32'h3, 2'd2}; // h3 accepted and shown
    vecs[7] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h0, 2'd0}; // drain

    step();
    pulse_reset();

    // Reset state
    check("rst_out_valid", bus_a.out_valid, 1'b0);
    check("rst_in_ready",  bus_a.in_ready,  1'b1);
    check("rst_out_data",  bus_a.out_data,  32'h0);
    check("rst_out_sel",   bus_a.out_sel,   2'd0);
    check("rst_sel_err",   err_a,           1'b0);
    check("rst_xfer_cnt",  cnt_a,           16'd0);
    check("rst_b_valid",   bus_b.out_valid, 1'b0);
    check("rst_b_ready",   bus_b.in_ready,  1'b1);

    // Tests 1/2: table-driven
    for (int i = 0; i < 8; i++) begin
      bus_a.in_valid  = vecs[i].iv;
      bus_a.sel       = vecs[i].sel;
      bus_a.out_ready = vecs[i].ordy;
      step();
      check($sformatf("vec%0d_out_valid", i), bus_a.out_valid, vecs[i].ev);
      check($sformatf("vec%0d_in_ready", i),  bus_a.in_ready,  vecs[i].er);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_out_data", i), bus_a.out_data, vecs[i].ed);
        check($sformatf("vec%0d_out_sel", i),  bus_a.out_sel,  vecs[i].es);
      end
    end
    check("vec_xfer_cnt", cnt_a, 16'd4);

    // Test 3: illegal select on N=3
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.sel       = 2'd3;
    step();
    check("ill_out_valid", bus_b.out_valid, 1'b1);
    check("ill_out_data",  bus_b.out_data,  32'h0);
    check("ill_out_sel",   bus_b.out_sel,   2'd3);
    check("ill_sel_err",   err_b,           1'b1);
    clr_b = 1'b1;
    step();
    check("ill_set_wins",  err_b,           1'b1);
    check("ill2_out_data", bus_b.out_data,  32'h0);
    bus_b.sel = 2'd1;
    step();
    check("clr_sel_err",   err_b,           1'b0);
    check("legal_data",    bus_b.out_data,  32'h20);
    check("legal_sel",     bus_b.out_sel,   2'd1);
    clr_b = 1'b0;
    bus_b.in_valid = 1'b0;
    step();
    check("b_drain_valid", bus_b.out_valid, 1'b0);

    // Test 4: 17 back-to-back transfers, 4-bit counter wraps to 1
    pulse_reset();
    check("b_rst_cnt", cnt_b, 4'd0);
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.sel      = 2'(i % 3);
      step();
      check($sformatf("tp%0d_valid", i), bus_b.out_valid, 1'b1);
      check($sformatf("tp%0d_ready", i), bus_b.in_ready,  1'b1);
      check($sformatf("tp%0d_data", i),  bus_b.out_data,  32'((i % 3 + 1) * 16));
    end
    bus_b.in_valid = 1'b0;
    step();
    check("tp_end_valid", bus_b.out_valid, 1'b0);
    check("tp_wrap_cnt",  cnt_b,           4'd1);
    bus_b.out_ready = 1'b0;

    // Test 5: reset while full discards both words
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.sel       = 2'd0;
    step();
    bus_a.sel = 2'd1;
    step();
    check("full_in_ready", bus_a.in_ready, 1'b0);
    bus_a.in_valid = 1'b0;
    pulse_reset();
    check("mrst_out_valid", bus_a.out_valid, 1'b0);
    check("mrst_in_ready",  bus_a.in_ready,  1'b1);
    check("mrst_xfer_cnt",  cnt_a,           16'd0);
    check("mrst_out_data",  bus_a.out_data,  32'h0);
    bus_a.out_ready = 1'b1;
    step();
    step();
    check("mrst_no_emit_valid", bus_a.out_valid, 1'b0);
    check("mrst_no_emit_cnt",   cnt_a,           16'd0);

    // Test 6: random traffic against a 2-deep FIFO occupancy model
    n_emit = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      rsel = 2'($urandom_range(0, 3));
      bus_a.in_valid  = ($urandom_range(0, 3) != 0);
      bus_a.out_ready = ($urandom_range(0, 2) != 0);
      bus_a.sel       = rsel;
      bus_a.in_data   = {w[3], w[2], w[1], w[0]};
      m_acc  = bus_a.in_valid  && (exp_q.size() < 2);
      m_emit = bus_a.out_ready && (exp_q.size() > 0);
      if (m_emit) begin
        e = exp_q.pop_front();
        check("rand_data", bus_a.out_data, e[31:0]);
        check("rand_sel",  bus_a.out_sel,  e[33:32]);
        n_emit++;
      end
      if (m_acc) exp_q.push_back({rsel, w[rsel]});
      step();
      check("rand_valid", bus_a.out_valid, (exp_q.size() > 0));
      check("rand_ready", bus_a.in_ready,  (exp_q.size() < 2));
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("drain_data", bus_a.out_data, e[31:0]);
        check("drain_sel",  bus_a.out_sel,  e[33:32]);
        n_emit++;
      end
      step();
    end
    check("rand_final_valid", bus_a.out_valid, 1'b0);
    check("rand_xfer_cnt",    cnt_a,           16'(n_emit));
    check("rand_no_err",      err_a,           1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
